// File: rtl/mfp_input_conditioner_pkg.sv
// Shared types and sizing helpers for the input conditioner.
// Counters are sized by cnt_width so a modulus of 1 still gets a legal 1-bit register.
package mfp_input_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mfp_input_conditioner_channel.sv
// One conditioned input: synchroniser, polarity fix, debounce, edge pulses,
// auto-repeat FSM and a write-1-to-clear sticky event flag.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | no repeat armed; waits for a press with repeat enabled
// ST_HOLD   | key held, counting ticks up to the first repeat
// ST_REPEAT | first repeat issued, pulsing every REPEAT_PERIOD ticks
module mfp_input_conditioner_channel
  import mfp_input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int DEBOUNCE_CYC  = 65536,
  parameter bit INVERT        = 1'b0,
  parameter int REPEAT_DELAY  = 25,
  parameter int REPEAT_PERIOD = 5
) (
  input  logic i_hclk,
  input  logic i_hresetn,
  input  logic i_raw,
  input  logic i_repeat_en,
  input  logic i_event_clear,
  input  logic i_tick,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat_pulse,
  output logic o_event_sticky
);

  localparam int DW   = cnt_width(DEBOUNCE_CYC);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = cnt_width(RMAX);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DW-1:0]          r_db_cnt;
  logic                   r_level;
  logic                   r_press;
  logic                   r_release;
  logic                   r_repeat;
  logic                   r_sticky;
  rep_state_e             r_state;
  logic [RW-1:0]          r_rcnt;

  logic w_s;
  logic w_change;
  logic w_rise;
  logic w_fall;

  assign w_s      = r_sync[SYNC_STAGES-1] ^ INVERT;
  assign w_change = (w_s != r_level) && (r_db_cnt == DB_LAST);
  assign w_rise   = w_change && w_s;
  assign w_fall   = w_change && !w_s;

  // Sync flops reset to the inactive pin level so leaving reset is never seen as a press.
  always_ff @(posedge i_hclk) begin
    if (!i_hresetn) begin
      r_sync    <= {SYNC_STAGES{INVERT}};
      r_db_cnt  <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_sticky  <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], i_raw};
      r_press   <= w_rise;
      r_release <= w_fall;
      if (w_s == r_level) begin
        r_db_cnt <= '0;
      end else if (w_change) begin
        r_level  <= w_s;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
      r_sticky <= (r_sticky & ~i_event_clear) | r_press | r_repeat;
    end
  end

  // Release or disable wins over a coincident tick, so no pulse on the exit cycle.
  always_ff @(posedge i_hclk) begin
    if (!i_hresetn) begin
      r_state  <= ST_IDLE;
      r_rcnt   <= '0;
      r_repeat <= 1'b0;
    end else begin
      r_repeat <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rise && i_repeat_en) begin
            r_state <= ST_HOLD;
            r_rcnt  <= '0;
          end
        end
        ST_HOLD: begin
          if (w_fall || !i_repeat_en) begin
            r_state <= ST_IDLE;
          end else if (i_tick) begin
            if (r_rcnt == RD_LAST) begin
              r_repeat <= 1'b1;
              r_state  <= ST_REPEAT;
              r_rcnt   <= '0;
            end else begin
              r_rcnt <= r_rcnt + 1'b1;
            end
          end
        end
        ST_REPEAT: begin
          if (w_fall || !i_repeat_en) begin
            r_state <= ST_IDLE;
          end else if (i_tick) begin
            if (r_rcnt == RP_LAST) begin
              r_repeat <= 1'b1;
              r_rcnt   <= '0;
            end else begin
              r_rcnt <= r_rcnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_level        = r_level;
  assign o_press        = r_press;
  assign o_release      = r_release;
  assign o_repeat_pulse = r_repeat;
  assign o_event_sticky = r_sticky;

endmodule

// File: rtl/mfp_input_conditioner.sv
// Multi-channel switch/button conditioner between board pins and the system GPIO.
// Owns the shared repeat tick and the OR of all sticky event flags.
module mfp_input_conditioner
  import mfp_input_conditioner_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter int               SYNC_STAGES   = 2,
  parameter int               DEBOUNCE_CYC  = 65536,
  parameter logic [WIDTH-1:0] INVERT_MASK   = '0,
  parameter int               TICK_DIV      = 50000,
  parameter int               REPEAT_DELAY  = 25,
  parameter int               REPEAT_PERIOD = 5
) (
  input  logic             i_hclk,
  input  logic             i_hresetn,
  input  logic [WIDTH-1:0] i_in_raw,
  input  logic [WIDTH-1:0] i_repeat_en,
  input  logic [WIDTH-1:0] i_event_clear,
  output logic [WIDTH-1:0] o_level,
  output logic [WIDTH-1:0] o_press,
  output logic [WIDTH-1:0] o_release,
  output logic [WIDTH-1:0] o_repeat_pulse,
  output logic [WIDTH-1:0] o_event_sticky,
  output logic             o_any_event
);

  localparam int TW = cnt_width(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] r_tick_cnt;
  logic          r_any_event;
  logic          w_tick;

  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge i_hclk) begin
    if (!i_hresetn) begin
      r_tick_cnt  <= '0;
      r_any_event <= 1'b0;
    end else begin
      r_tick_cnt  <= w_tick ? '0 : r_tick_cnt + 1'b1;
      r_any_event <= |o_event_sticky;
    end
  end

  genvar g;
  for (g = 0; g < WIDTH; g++) begin : g_ch
    mfp_input_conditioner_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .INVERT       (INVERT_MASK[g]),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .i_hclk        (i_hclk),
      .i_hresetn     (i_hresetn),
      .i_raw         (i_in_raw[g]),
      .i_repeat_en   (i_repeat_en[g]),
      .i_event_clear (i_event_clear[g]),
      .i_tick        (w_tick),
      .o_level       (o_level[g]),
      .o_press       (o_press[g]),
      .o_release     (o_release[g]),
      .o_repeat_pulse(o_repeat_pulse[g]),
      .o_event_sticky(o_event_sticky[g])
    );
  end

  assign o_any_event = r_any_event;

endmodule

// File: tb/tb_mfp_input_conditioner.sv
// Directed bench: 4 channels, 2 sync stages, 4-cycle debounce, tick every 2 cycles,
// first repeat after 3 ticks then every 2 ticks; channel 3 is active-low.
module tb_mfp_input_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_raw;
  logic [3:0] repeat_en;
  logic [3:0] event_clear;
  logic [3:0] o_level;
  logic [3:0] o_press;
  logic [3:0] o_release;
  logic [3:0] o_repeat_pulse;
  logic [3:0] o_event_sticky;
  logic       o_any_event;

  int errors = 0;
  int checks = 0;

  mfp_input_conditioner #(
    .WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYC(4), .INVERT_MASK(4'h8),
    .TICK_DIV(2), .REPEAT_DELAY(3), .REPEAT_PERIOD(2)
  ) dut (
    .i_hclk(clk), .i_hresetn(rst_n), .i_in_raw(in_raw), .i_repeat_en(repeat_en),
    .i_event_clear(event_clear), .o_level(o_level), .o_press(o_press),
    .o_release(o_release), .o_repeat_pulse(o_repeat_pulse),
    .o_event_sticky(o_event_sticky), .o_any_event(o_any_event)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_all();
    event_clear = 4'hF;
    step(1);
    event_clear = 4'h0;
    step(2);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_raw = 4'hF; repeat_en = 4'h0; event_clear = 4'h0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      checks++;
      if ({o_level, o_press, o_release, o_repeat_pulse, o_event_sticky, o_any_event} !== 21'h0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got lvl=%b prs=%b rel=%b rep=%b stk=%b any=%b exp all 0",
                 k, o_level, o_press, o_release, o_repeat_pulse, o_event_sticky, o_any_event);
      end
    end
    rst_n = 1'b1; in_raw = 4'h8;
    step(10);
    checks++;
    if (o_level !== 4'h0 || o_event_sticky !== 4'h0 || o_any_event !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got lvl=%b stk=%b any=%b exp 0000/0000/0", o_level, o_event_sticky, o_any_event);
    end
  endtask

  task automatic test_clean_press();
    logic exp_b;
    in_raw[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      exp_b = (k == 6);
      checks++;
      if (o_level[0] !== exp_b || o_press[0] !== exp_b || o_release[0] !== 1'b0) begin
        errors++;
        $display("FAIL press_latency k=%0d got lvl=%b prs=%b rel=%b exp lvl=%b prs=%b rel=0",
                 k, o_level[0], o_press[0], o_release[0], exp_b, exp_b);
      end
    end
    step(1);
    checks++;
    if (o_press[0] !== 1'b0 || o_level[0] !== 1'b1 || o_event_sticky[0] !== 1'b1) begin
      errors++;
      $display("FAIL press_width got prs=%b lvl=%b stk=%b exp 0/1/1", o_press[0], o_level[0], o_event_sticky[0]);
    end
    step(1);
    checks++;
    if (o_any_event !== 1'b1) begin
      errors++;
      $display("FAIL press_any got=%b exp=1", o_any_event);
    end
    in_raw[0] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (o_level[0] !== (k < 6) || o_release[0] !== (k == 6) || o_press[0] !== 1'b0) begin
        errors++;
        $display("FAIL release_latency k=%0d got lvl=%b rel=%b prs=%b exp lvl=%b rel=%b prs=0",
                 k, o_level[0], o_release[0], o_press[0], k < 6, k == 6);
      end
    end
    step(1);
    checks++;
    if (o_release[0] !== 1'b0 || o_event_sticky[0] !== 1'b1) begin
      errors++;
      $display("FAIL release_width got rel=%b stk=%b exp 0/1", o_release[0], o_event_sticky[0]);
    end
    event_clear = 4'hF;
    step(1);
    event_clear = 4'h0;
    checks++;
    if (o_event_sticky !== 4'h0) begin
      errors++;
      $display("FAIL clear_sticky got=%b exp=0000", o_event_sticky);
    end
    step(1);
    checks++;
    if (o_any_event !== 1'b0) begin
      errors++;
      $display("FAIL clear_any got=%b exp=0", o_any_event);
    end
  endtask

  task automatic test_bounce();
    int rise_at = -1;
    int np = 0;
    int nr = 0;
    for (int c = 0; c < 16; c++) begin
      in_raw[1] = !(c == 2 || c == 3);
      @(negedge clk);
      if (o_press[1] === 1'b1) np++;
      if (o_release[1] === 1'b1) nr++;
      if (o_level[1] === 1'b1 && rise_at < 0) rise_at = c;
    end
    checks++;
    if (rise_at !== 9) begin
      errors++;
      $display("FAIL bounce_rise got=%0d exp=9", rise_at);
    end
    checks++;
    if (np !== 1 || nr !== 0) begin
      errors++;
      $display("FAIL bounce_pulses got press=%0d release=%0d exp 1/0", np, nr);
    end
    in_raw[1] = 1'b0;
    step(10);
    clear_all();
  endtask

  task automatic test_auto_repeat();
    int press_k = -1;
    int rel_k = -1;
    int q[$];
    int bad_gap = 0;
    repeat_en[2] = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      in_raw[2] = (k <= 40);
      @(negedge clk);
      if (o_press[2] === 1'b1 && press_k < 0) press_k = k;
      if (o_release[2] === 1'b1 && rel_k < 0) rel_k = k;
      if (o_repeat_pulse[2] === 1'b1) q.push_back(k);
    end
    checks++;
    if (press_k !== 6 || rel_k !== 46) begin
      errors++;
      $display("FAIL repeat_edges got press=%0d release=%0d exp 6/46", press_k, rel_k);
    end
    checks++;
    if (q.size() !== 9) begin
      errors++;
      $display("FAIL repeat_count got=%0d exp=9", q.size());
    end
    checks++;
    if (q.size() == 0 || (q[0] - 6) < 5 || (q[0] - 6) > 6) begin
      errors++;
      $display("FAIL repeat_first got=%0d exp 5..6 cycles after press", (q.size() == 0) ? -1 : q[0] - 6);
    end
    for (int i = 1; i < q.size(); i++) if (q[i] - q[i-1] != 4) bad_gap++;
    checks++;
    if (bad_gap !== 0) begin
      errors++;
      $display("FAIL repeat_period got %0d gaps not 4 exp 0", bad_gap);
    end
    checks++;
    if (q.size() == 0 || q[q.size()-1] >= 46) begin
      errors++;
      $display("FAIL repeat_after_release got last=%0d exp <46", (q.size() == 0) ? -1 : q[q.size()-1]);
    end
    repeat_en[2] = 1'b0;
    clear_all();
  endtask

  task automatic test_sticky_w1c();
    bit found = 0;
    repeat_en[0] = 1'b1;
    in_raw[0] = 1'b1;
    step(7);
    checks++;
    if (o_event_sticky[0] !== 1'b1) begin
      errors++;
      $display("FAIL w1c_set got=%b exp=1", o_event_sticky[0]);
    end
    event_clear[0] = 1'b1;
    step(1);
    event_clear[0] = 1'b0;
    checks++;
    if (o_event_sticky[0] !== 1'b0) begin
      errors++;
      $display("FAIL w1c_clear got=%b exp=0", o_event_sticky[0]);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_repeat_pulse[0] === 1'b1) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL w1c_wait_repeat got none in 20 cycles exp a pulse");
    end else begin
      event_clear[0] = 1'b1;
      step(1);
      checks++;
      if (o_event_sticky[0] !== 1'b1) begin
        errors++;
        $display("FAIL w1c_set_wins got=%b exp=1", o_event_sticky[0]);
      end
      step(1);
      checks++;
      if (o_event_sticky[0] !== 1'b0 || o_any_event !== 1'b1) begin
        errors++;
        $display("FAIL w1c_clear_alone got stk=%b any=%b exp 0/1", o_event_sticky[0], o_any_event);
      end
      event_clear[0] = 1'b0;
      step(1);
      checks++;
      if (o_any_event !== 1'b0) begin
        errors++;
        $display("FAIL w1c_any_drop got=%b exp=0", o_any_event);
      end
    end
    repeat_en[0] = 1'b0;
    in_raw[0] = 1'b0;
    step(10);
    clear_all();
  endtask

  task automatic test_inverted();
    checks++;
    if (o_level[3] !== 1'b0) begin
      errors++;
      $display("FAIL inv_idle got=%b exp=0", o_level[3]);
    end
    in_raw[3] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (o_level[3] !== (k == 6) || o_press[3] !== (k == 6)) begin
        errors++;
        $display("FAIL inv_press k=%0d got lvl=%b prs=%b exp %b/%b", k, o_level[3], o_press[3], k == 6, k == 6);
      end
    end
    in_raw[3] = 1'b1;
    step(6);
    checks++;
    if (o_release[3] !== 1'b1 || o_level[3] !== 1'b0) begin
      errors++;
      $display("FAIL inv_release got rel=%b lvl=%b exp 1/0", o_release[3], o_level[3]);
    end
    step(2);
    clear_all();
  endtask

  task automatic test_reset_mid_hold();
    int np = 0;
    int nr = 0;
    int nrep = 0;
    repeat_en[2] = 1'b1;
    in_raw[2] = 1'b1;
    step(6);
    checks++;
    if (o_press[2] !== 1'b1) begin
      errors++;
      $display("FAIL mid_press got=%b exp=1", o_press[2]);
    end
    step(2);
    rst_n = 1'b0;
    in_raw[2] = 1'b0;
    step(1);
    checks++;
    if ({o_level, o_press, o_release, o_repeat_pulse, o_event_sticky, o_any_event} !== 21'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs got lvl=%b stk=%b any=%b exp all 0", o_level, o_event_sticky, o_any_event);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_repeat_pulse[2] === 1'b1) nrep++;
      if (o_press[2] === 1'b1) np++;
      if (o_release[2] === 1'b1) nr++;
    end
    checks++;
    if (nrep !== 0 || np !== 0 || nr !== 0 || o_level[2] !== 1'b0) begin
      errors++;
      $display("FAIL mid_after_reset got rep=%0d prs=%0d rel=%0d lvl=%b exp 0/0/0/0", nrep, np, nr, o_level[2]);
    end
    in_raw[2] = 1'b1;
    np = 0; nrep = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (o_press[2] === 1'b1) np++;
      if (o_repeat_pulse[2] === 1'b1) nrep++;
    end
    checks++;
    if (np !== 1 || nrep !== 2) begin
      errors++;
      $display("FAIL mid_new_press got prs=%0d rep=%0d exp 1/2", np, nrep);
    end
    repeat_en[2] = 1'b0;
    in_raw[2] = 1'b0;
    step(10);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_sticky_w1c();
    test_inverted();
    test_reset_mid_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
